// File: rtl/fp_add_mc.sv
// fp_add_mc: multicycle IEEE-754 single-precision adder/subtractor.
// Sequence: IDLE -> ALIGN -> ADD -> NORM -> DONE -> IDLE, one cycle per state.
// Operands are unpacked and specials classified on the accepting edge.
// Rounding is toward zero. Denormal inputs are flushed to signed zero.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high, clears all state
//   start  - request strobe, sampled only in IDLE
//   sub    - 0 = a+b, 1 = a-b (captured with start)
//   a, b   - IEEE single operands (captured with start)
//   busy   - high whenever not IDLE
//   done   - one-cycle pulse, result valid in that cycle
//   result - sum/difference, held until the next operation completes
module fp_add_mc #(
  parameter logic [31:0] NAN_CANON = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;
  state_t r_state, w_state_next;

  // ---------------- unpack / special classification (combinational on inputs)
  logic [7:0]  w_ea, w_eb;
  logic        w_sb;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic        w_special;
  logic [31:0] w_spec_val;

  assign w_ea     = a[30:23];
  assign w_eb     = b[30:23];
  assign w_sb     = b[31] ^ sub;
  assign w_a_nan  = (&w_ea) && (|a[22:0]);
  assign w_b_nan  = (&w_eb) && (|b[22:0]);
  assign w_a_inf  = (&w_ea) && !(|a[22:0]);
  assign w_b_inf  = (&w_eb) && !(|b[22:0]);
  assign w_a_zero = (w_ea == 8'd0);
  assign w_b_zero = (w_eb == 8'd0);

  always_comb begin
    w_special  = 1'b1;
    w_spec_val = 32'h0;
    if (w_a_nan || w_b_nan)
      w_spec_val = NAN_CANON;
    else if (w_a_inf && w_b_inf)
      w_spec_val = (a[31] != w_sb) ? NAN_CANON : {a[31], 8'hFF, 23'd0};
    else if (w_a_inf)
      w_spec_val = {a[31], 8'hFF, 23'd0};
    else if (w_b_inf)
      w_spec_val = {w_sb, 8'hFF, 23'd0};
    else if (w_a_zero && w_b_zero)
      w_spec_val = {a[31] & w_sb, 31'd0};
    else if (w_a_zero)
      w_spec_val = {w_sb, b[30:0]};
    else if (w_b_zero)
      w_spec_val = a;
    else
      w_special = 1'b0;
  end

  // Unpacked operand registers (27-bit significand = hidden, frac, G, R, S)
  logic        r_sa, r_sb;
  logic [7:0]  r_ea, r_eb;
  logic [26:0] r_ma, r_mb;
  logic        r_special;
  logic [31:0] r_spec_val;

  // ---------------- ALIGN
  logic        w_a_ge;
  logic [7:0]  w_ex, w_ey, w_d;
  logic [26:0] w_xm, w_ym_raw, w_ym_sh, w_ym_mask, w_ym;
  logic        w_xs;

  assign w_a_ge    = {r_ea, r_ma} >= {r_eb, r_mb};
  assign w_ex      = w_a_ge ? r_ea : r_eb;
  assign w_ey      = w_a_ge ? r_eb : r_ea;
  assign w_xm      = w_a_ge ? r_ma : r_mb;
  assign w_ym_raw  = w_a_ge ? r_mb : r_ma;
  assign w_xs      = w_a_ge ? r_sa : r_sb;
  assign w_d       = w_ex - w_ey;
  assign w_ym_sh   = w_ym_raw >> w_d;
  assign w_ym_mask = (27'd1 << w_d) - 27'd1;
  // Beyond 26 positions nothing but the sticky bit survives.
  assign w_ym      = (w_d >= 8'd27) ? {26'd0, |w_ym_raw}
                                    : {w_ym_sh[26:1], w_ym_sh[0] | (|(w_ym_raw & w_ym_mask))};

  logic [26:0] r_xm, r_ym;
  logic [7:0]  r_exp;
  logic        r_sign, r_eff_sub;

  // ---------------- ADD
  logic [27:0] r_sum;

  // ---------------- NORM
  logic [4:0]        w_lzc;
  logic              w_found;
  logic [26:0]       w_mant;
  logic signed [9:0] w_exp_n;
  logic [31:0]       w_packed, w_result_next;
  logic              w_unused_bits;

  always_comb begin
    w_lzc   = 5'd0;
    w_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!w_found) begin
        if (r_sum[i]) w_found = 1'b1;
        else          w_lzc   = w_lzc + 5'd1;
      end
    end
  end

  always_comb begin
    w_mant   = 27'd0;
    w_exp_n  = 10'sd0;
    w_packed = 32'h0;
    if (r_sum[27]) begin
      w_mant  = {r_sum[27:2], r_sum[1] | r_sum[0]};
      w_exp_n = $signed({2'b00, r_exp}) + 10'sd1;
    end else begin
      w_mant  = r_sum[26:0] << w_lzc;
      w_exp_n = $signed({2'b00, r_exp}) - $signed({5'd0, w_lzc});
    end
    if (r_sum == 28'd0)
      w_packed = 32'h0;
    else if (w_exp_n >= 10'sd255)
      w_packed = {r_sign, 8'hFF, 23'd0};
    else if (w_exp_n <= 10'sd0)
      w_packed = {r_sign, 31'd0};
    else
      w_packed = {r_sign, w_exp_n[7:0], w_mant[25:3]};  // G/R/S dropped: round toward zero
  end

  assign w_unused_bits = ^{w_mant[26], w_mant[2:0], w_exp_n[9:8]};
  assign w_result_next = r_special ? r_spec_val : w_packed;

  // ---------------- FSM
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_ALIGN;
      S_ALIGN: w_state_next = S_ADD;
      S_ADD:   w_state_next = S_NORM;
      S_NORM:  w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sa <= 1'b0; r_sb <= 1'b0; r_ea <= 8'd0; r_eb <= 8'd0;
      r_ma <= 27'd0; r_mb <= 27'd0; r_special <= 1'b0; r_spec_val <= 32'h0;
      r_xm <= 27'd0; r_ym <= 27'd0; r_exp <= 8'd0; r_sign <= 1'b0; r_eff_sub <= 1'b0;
      r_sum <= 28'd0;
      result <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_sa       <= a[31];
          r_sb       <= w_sb;
          r_ea       <= w_ea;
          r_eb       <= w_eb;
          r_ma       <= {1'b1, a[22:0], 3'b000};
          r_mb       <= {1'b1, b[22:0], 3'b000};
          r_special  <= w_special;
          r_spec_val <= w_spec_val;
        end
        S_ALIGN: begin
          r_xm      <= w_xm;
          r_ym      <= w_ym;
          r_exp     <= w_ex;
          r_sign    <= w_xs;
          r_eff_sub <= r_sa ^ r_sb;
        end
        S_ADD:   r_sum  <= r_eff_sub ? ({1'b0, r_xm} - {1'b0, r_ym}) : ({1'b0, r_xm} + {1'b0, r_ym});
        S_NORM:  result <= w_result_next;
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_fp_add_mc.sv
// Testbench for fp_add_mc: directed cases with known answers, randomized
// operands against an exact wide-integer reference model, start-while-busy
// and asynchronous reset scenarios.
module tb_fp_add_mc;

  logic        clk = 1'b0;
  logic        reset, start, sub;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  fp_add_mc dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Reference: exact sum of the two values as large integers, then truncate.
  function automatic logic [31:0] model(input logic [31:0] fa, input logic [31:0] fb, input logic fs);
    logic        sa, sb, s;
    int          ea, eb, p, e;
    logic [299:0] va, vb, m, t;
    sa = fa[31]; sb = fb[31] ^ fs;
    ea = int'(fa[30:23]); eb = int'(fb[30:23]);
    if ((ea == 255 && fa[22:0] != 0) || (eb == 255 && fb[22:0] != 0)) return 32'h7FC00000;
    if (ea == 255 && eb == 255) return (sa != sb) ? 32'h7FC00000 : {sa, 8'hFF, 23'd0};
    if (ea == 255) return {sa, 8'hFF, 23'd0};
    if (eb == 255) return {sb, 8'hFF, 23'd0};
    if (ea == 0 && eb == 0) return (sa && sb) ? 32'h80000000 : 32'h0;
    if (ea == 0) return {sb, fb[30:0]};
    if (eb == 0) return fa;
    va = {276'd0, 1'b1, fa[22:0]}; va = va << (ea - 1);
    vb = {276'd0, 1'b1, fb[22:0]}; vb = vb << (eb - 1);
    if (sa == sb)      begin m = va + vb; s = sa; end
    else if (va >= vb) begin m = va - vb; s = sa; end
    else               begin m = vb - va; s = sb; end
    if (m == 0) return 32'h0;
    p = 0;
    for (int i = 299; i >= 0; i--) if (m[i]) begin p = i; break; end
    e = p - 22;
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    t = m >> (p - 23);
    return {s, e[7:0], t[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op(input int base);
    int sel, e;
    logic [31:0] v;
    sel = int'($urandom_range(0, 15));
    v = $urandom;
    if (sel == 0)      v[30:23] = 8'd0;
    else if (sel == 1) begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
    else if (sel == 2) begin v[30:23] = 8'hFF; v[0] = 1'b1; end
    else begin
      e = base + int'($urandom_range(0, 60)) - 30;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
      v[30:23] = e[7:0];
    end
    return v;
  endfunction

  // One full transaction with latency/busy/done checks and an expected result.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                       input logic [31:0] expv, input string tag);
    int lat, busy_cnt;
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
    check({tag, "_result"}, result, expv);
    $display("op %s: a=%h b=%h sub=%0d result=%h expected=%h", tag, ta, tb_v, ts, result, expv);
    @(posedge clk); #1;
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, result, expv);
  endtask

  initial begin
    logic [31:0] ra, rb, exp1;
    logic        rs;
    int          base, dones, busy_seen;

    reset = 1'b1; start = 1'b0; sub = 1'b0; a = 32'h0; b = 32'h0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'h0);
    @(negedge clk); reset = 1'b0;

    // Directed known-answer cases
    do_op(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, "one_plus_two");
    do_op(32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, "1p5_minus_1");
    do_op(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, "one_minus_one");
    do_op(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, "inf_minus_inf");
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, "overflow");
    do_op(32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, "tiny_add_trunc");
    do_op(32'h3F800000, 32'hB0800000, 1'b0, 32'h3F7FFFFF, "tiny_sub_sticky");
    do_op(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, "negzero_minus_zero");
    do_op(32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, "zero_minus_two");
    do_op(32'h7FC01234, 32'h3F800000, 1'b0, 32'h7FC00000, "nan_in");
    do_op(32'h00800000, 32'h80800001, 1'b0, 32'h80000000, "underflow");

    // Randomized operands against the reference model
    for (int n = 0; n < 200; n++) begin
      base = int'($urandom_range(1, 254));
      ra = rnd_op(base); rb = rnd_op(base); rs = 1'($urandom_range(0, 1));
      do_op(ra, rb, rs, model(ra, rb, rs), "rand");
    end

    // Start pulses during ALIGN and DONE are ignored
    exp1 = model(32'h40A00000, 32'h3F800000, 1'b0);
    dones = 0; busy_seen = 0;
    @(negedge clk); a = 32'h40A00000; b = 32'h3F800000; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); a = 32'h41200000; b = 32'h41200000; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (done) dones++;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("ignored_busy_after_done", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (busy) busy_seen++;
    end
    check("ignored_done_count", 32'(dones), 32'd1);
    check("ignored_busy_seen", 32'(busy_seen), 32'd0);
    check("ignored_result", result, exp1);
    $display("op ignored_starts: result=%h expected=%h dones=%0d", result, exp1, dones);

    // Asynchronous reset in the ADD cycle
    dones = 0;
    @(negedge clk); a = 32'h40400000; b = 32'h40800000; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("areset_busy", {31'd0, busy}, 32'd0);
    check("areset_done", {31'd0, done}, 32'd0);
    check("areset_result", result, 32'h0);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("areset_no_done", 32'(dones), 32'd0);
    $display("op async_reset: dones_after_reset=%0d", dones);
    do_op(32'h40400000, 32'h40800000, 1'b0, 32'h40E00000, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
